// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared widths, reset PC, FSM encoding and if_id_bus layout
package ifu_fetch_pkg;

   localparam int PC_WIDTH        = 32;
   localparam int DATA_WIDTH      = 32;
   localparam int IF_ID_BUS_WIDTH = 2 * PC_WIDTH + DATA_WIDTH;

   localparam logic [PC_WIDTH-1:0] RESET_PC      = 32'h8000_0000;
   localparam logic [PC_WIDTH-1:0] PC_ALIGN_MASK = ~PC_WIDTH'(3);
   localparam logic [PC_WIDTH-1:0] PC_STEP       = PC_WIDTH'(4);

   typedef enum logic {
      FETCH = 1'b0,
      WAIT  = 1'b1
   } fetch_state_e;

   // Field order is shared with decode: PC in the MSBs, PC+4 in the LSBs.
   typedef struct packed {
      logic [PC_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]   pc_4;
   } if_id_t;

   function automatic if_id_t pack_if_id(input logic [PC_WIDTH-1:0] pc,
                                         input logic [DATA_WIDTH-1:0] instr);
      if_id_t r;
      r.pc    = pc;
      r.instr = instr;
      r.pc_4  = pc + PC_STEP;
      return r;
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - redirect, imem request/response and if_id_bus handshake bundle
interface ifu_fetch_if;
   import ifu_fetch_pkg::*;

   logic                       redirect_valid;
   logic [PC_WIDTH-1:0]        redirect_pc;
   logic                       imem_req_valid;
   logic                       imem_req_ready;
   logic [PC_WIDTH-1:0]        imem_req_addr;
   logic                       imem_resp_valid;
   logic [DATA_WIDTH-1:0]      imem_resp_data;
   logic                       m_valid;
   logic                       m_ready;
   logic [IF_ID_BUS_WIDTH-1:0] if_id_bus;

   modport master (
      input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
             imem_resp_data, m_ready,
      output imem_req_valid, imem_req_addr, m_valid, if_id_bus
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
             imem_resp_data, m_ready,
      input  imem_req_valid, imem_req_addr, m_valid, if_id_bus
   );

endinterface

// File: rtl/ifu_fetch_if_out_slot.sv
// rtl/ifu_fetch_if_out_slot.sv - single-entry output register with load, pop and flush
module if_out_slot
   import ifu_fetch_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  if_id_t load_data,
   input  logic   pop,
   input  logic   flush,
   output logic   valid,
   output if_id_t data
);

   logic   valid_q, valid_d;
   if_id_t data_q, data_d;

   // Flush beats load beats pop; data is held on pop/flush so the bus stays quiet.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (load) begin
         valid_d = 1'b1;
         data_d  = load_data;
      end else if (pop) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction-fetch stage: PC, single-outstanding imem reads, redirect flush
module ifu_fetch
   import ifu_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   ifu_fetch_if.master bus
);

   fetch_state_e        state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                kill_q, kill_d;

   logic   slot_valid;
   if_id_t slot_data;
   logic   slot_load;
   logic   m_valid;
   logic   m_pop;
   logic   can_issue;
   logic   req_valid;

   assign m_valid   = slot_valid & ~bus.redirect_valid & rst;
   assign m_pop     = m_valid & bus.m_ready;
   assign can_issue = ~slot_valid | m_pop;
   assign req_valid = (state_q == FETCH) & can_issue & ~bus.redirect_valid & rst;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      kill_d    = kill_q;
      slot_load = 1'b0;
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc & PC_ALIGN_MASK;
         if (state_q == WAIT) begin
            // A response landing with the redirect is simply discarded.
            if (bus.imem_resp_valid) begin
               state_d = FETCH;
               kill_d  = 1'b0;
            end else begin
               kill_d  = 1'b1;
            end
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (req_valid && bus.imem_req_ready) begin
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_resp_valid) begin
                  state_d = FETCH;
                  if (kill_q) begin
                     kill_d = 1'b0;
                  end else begin
                     slot_load = 1'b1;
                     pc_d      = pc_q + PC_STEP;
                  end
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         kill_q  <= kill_d;
      end
   end

   if_out_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load),
      .load_data (pack_if_id(pc_q, bus.imem_resp_data)),
      .pop       (m_pop),
      .flush     (bus.redirect_valid),
      .valid     (slot_valid),
      .data      (slot_data)
   );

   assign bus.imem_req_valid = req_valid;
   assign bus.imem_req_addr  = pc_q;
   assign bus.m_valid        = m_valid;
   assign bus.if_id_bus      = rst ? slot_data : '0;

endmodule
